// File: rtl/core_pkg.sv
// Shared core types: word width and 2-bit saturating counter encoding.
package core_pkg;

    localparam int WORD_SIZE = 32;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'b00;
    localparam ctr_t CTR_WNT = 2'b01;
    localparam ctr_t CTR_WT  = 2'b10;
    localparam ctr_t CTR_ST  = 2'b11;

endpackage

// File: rtl/sat_counter2.sv
// One 2-bit saturating direction counter; resets to weakly not-taken.
module sat_counter2
    import core_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic en,
    input  logic up,
    output ctr_t ctr
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ctr <= CTR_WNT;
        end else if (en) begin
            if (up && ctr != CTR_ST)
                ctr <= ctr + 2'd1;
            else if (!up && ctr != CTR_SNT)
                ctr <= ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch direction predictor with registered outputs.
// Define BRANCH_PREDICTOR_GSHARE_EN to XOR global history into the index.
module branch_predictor
    import core_pkg::*;
#(
    parameter int WordSize  = WORD_SIZE,
    parameter int Entries   = 64,
    parameter int IndexBits = $clog2(Entries),
    parameter int HistBits  = 6
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                lookup_valid,
    input  logic [WordSize-1:0] lookup_pc,
    input  logic [WordSize-1:0] lookup_off,
    input  logic                flush,
    input  logic                upd_valid,
    input  logic [WordSize-1:0] upd_pc,
    input  logic                upd_taken,
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    input  logic [HistBits-1:0] upd_ghr,
    output logic [HistBits-1:0] pred_ghr,
`endif
    output logic                pred_valid,
    output logic                pred_taken,
    output logic [WordSize-1:0] pred_pc,
    output logic [WordSize-1:0] pred_addr
);

    if (Entries < 2 || HistBits > IndexBits) begin : g_bad_cfg
        $error("branch_predictor: bad Entries/HistBits");
    end

    ctr_t                 ctrs [Entries];
    logic [IndexBits-1:0] lk_idx;
    logic [IndexBits-1:0] up_idx;
    logic                 unused_upd;

    assign unused_upd = ^{upd_pc[WordSize-1:IndexBits+2], upd_pc[1:0]};

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [HistBits-1:0] ghr;

    assign lk_idx = lookup_pc[IndexBits+1:2] ^ IndexBits'(ghr);
    assign up_idx = upd_pc[IndexBits+1:2] ^ IndexBits'(upd_ghr);

    // A flush carries the resolved branch's history, repairing speculative drift
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            ghr <= '0;
        else if (upd_valid && flush)
            ghr <= {upd_ghr[HistBits-2:0], upd_taken};
        else if (upd_valid)
            ghr <= {ghr[HistBits-2:0], upd_taken};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            pred_ghr <= '0;
        else if (lookup_valid && !flush)
            pred_ghr <= ghr;
    end
`else
    assign lk_idx = lookup_pc[IndexBits+1:2];
    assign up_idx = upd_pc[IndexBits+1:2];
`endif

    for (genvar i = 0; i < Entries; i++) begin : g_ctr
        sat_counter2 u_ctr (
            .clk  (clk),
            .rstn (rstn),
            .en   (upd_valid && up_idx == IndexBits'(i)),
            .up   (upd_taken),
            .ctr  (ctrs[i])
        );
    end

    // Table read uses the pre-update counter, so same-cycle updates are unseen
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            pred_pc    <= '0;
            pred_addr  <= '0;
        end else if (flush || !lookup_valid) begin
            pred_valid <= 1'b0;
        end else begin
            pred_valid <= 1'b1;
            pred_taken <= ctrs[lk_idx][1];
            pred_pc    <= lookup_pc;
            pred_addr  <= lookup_pc + lookup_off;
        end
    end

endmodule
